// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer slice.
// Holds the 5-bit major opcode values returned by the instruction decoder,
// register address and instruction-format types, the sequencer state enum,
// the NOP constant used to initialise the instruction register, and small
// helpers for legal-opcode checks and branch offset extension.
package core_sequencer_pkg;

  // Major opcode is instr[6:2]; instr[1:0] must be 2'b11 for 32-bit encodings
  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000,
    OPC_OP_IMM = 5'b00100,
    OPC_STORE  = 5'b01000,
    OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101,
    OPC_BRANCH = 5'b11000
  } OpCode;

  typedef logic [4:0] RegAddr;

  typedef struct packed {
    logic [6:0] funct7;
    RegAddr     rs2;
    RegAddr     rs1;
    logic [2:0] funct3;
    RegAddr     rd;
    logic [6:0] opcode;
  } RTypeInstr;

  typedef struct packed {
    logic [11:0] imm;
    RegAddr      rs1;
    logic [2:0]  funct3;
    RegAddr      rd;
    logic [6:0]  opcode;
  } ITypeInstr;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } SeqState;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] QUADRANT_32BIT = 2'b11;

  function automatic logic isLegalOp(input logic [4:0] op);
    case (op)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP_IMM, OPC_OP, OPC_LUI: isLegalOp = 1'b1;
      default: isLegalOp = 1'b0;
    endcase
  endfunction

  function automatic logic usesImmediate(input OpCode op);
    usesImmediate = (op == OPC_OP_IMM) || (op == OPC_LOAD) ||
                    (op == OPC_STORE)  || (op == OPC_LUI);
  endfunction

  // Branch offsets are in half-words: append a zero and sign-extend to 32 bits
  function automatic logic [31:0] branchOffset(input logic [11:0] off);
    branchOffset = {{19{off[11]}}, off, 1'b0};
  endfunction

endpackage

// File: rtl/core_sequencer_pc_unit.sv
// Program counter unit for the core sequencer.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   i_advance       pc <= pc + 4 at the next rising edge
//   i_branch        pc <= pc + sext({i_jumpOffset,1'b0}); wins over i_advance
//   i_jumpOffset    signed half-word branch offset
//   o_pc            current program counter (wraps modulo 2^32)
module core_sequencer_pc_unit
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_advance,
  input  logic        i_branch,
  input  logic [11:0] i_jumpOffset,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_pcBranch;

  assign w_pcPlus4  = r_pc + 32'd4;
  assign w_pcBranch = r_pc + branchOffset(i_jumpOffset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_branch) begin
      r_pc <= w_pcBranch;
    end else if (i_advance) begin
      r_pc <= w_pcPlus4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req/imem_ack/imem_rdata     instruction fetch handshake at address pc
//   instr                            instruction register to the external decoder
//   op_code, jump_offset             decoder results for instr
//   branch_taken                     ALU compare result, sampled in EXEC
//   pc                               current program counter
//   alu_src_imm                      ALU operand B is the immediate (EXEC only)
//   dmem_req/dmem_we/dmem_ack        data memory handshake
//   reg_we                           one-cycle register file write strobe
//   illegal                          illegal-instruction flag (held until reset)
//   instret                          retired-instruction counter
module core_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_sequencer_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [4:0]  op_code,
  input  logic [11:0] jump_offset,
  input  logic        branch_taken,
  output logic [31:0] pc,
  output logic        alu_src_imm,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        illegal,
  output logic [31:0] instret
);
  import core_sequencer_pkg::*;

  SeqState     r_state;
  SeqState     w_nextState;
  logic [31:0] r_instr;
  OpCode       r_opcode;
  logic [31:0] r_instret;
  logic        w_pcAdvance;
  logic        w_pcBranch;
  logic        w_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The legality check uses the latched word, which still holds the fetched
  // instruction during DECODE, plus the decoder's view of it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FETCH:  if (imem_ack) w_nextState = ST_DECODE;
      ST_DECODE: begin
        if ((r_instr[1:0] == QUADRANT_32BIT) && isLegalOp(op_code)) begin
          w_nextState = ST_EXEC;
        end else begin
          w_nextState = ST_TRAP;
        end
      end
      ST_EXEC: begin
        case (r_opcode)
          OPC_LOAD, OPC_STORE: w_nextState = ST_MEM;
          OPC_BRANCH:          w_nextState = ST_FETCH;
          default:             w_nextState = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          w_nextState = (r_opcode == OPC_STORE) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB:   w_nextState = ST_FETCH;
      ST_TRAP: w_nextState = ST_TRAP;
      default: w_nextState = ST_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so that asserting reset clears every request
  // and strobe immediately, without waiting for a clock edge.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    w_pcAdvance = 1'b0;
    w_pcBranch  = 1'b0;
    w_retire    = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: imem_req = 1'b1;
        ST_EXEC: begin
          alu_src_imm = usesImmediate(r_opcode);
          if (r_opcode == OPC_BRANCH) begin
            w_pcBranch  = branch_taken;
            w_pcAdvance = !branch_taken;
          end
        end
        ST_MEM: begin
          dmem_req    = 1'b1;
          dmem_we     = (r_opcode == OPC_STORE);
          w_pcAdvance = dmem_ack && (r_opcode == OPC_STORE);
        end
        ST_WB: begin
          reg_we      = 1'b1;
          w_pcAdvance = 1'b1;
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
      w_retire = (w_nextState == ST_FETCH) &&
                 ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB));
    end
  end

  // Instruction word is captured on the fetch acknowledge; the decoder's
  // opcode is latched in DECODE so later states do not depend on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= NOP_INSTR;
      r_opcode <= OPC_OP_IMM;
    end else begin
      if ((r_state == ST_FETCH) && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (r_state == ST_DECODE) begin
        r_opcode <= OpCode'(op_code);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= 32'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  core_sequencer_pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pcUnit (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_advance    (w_pcAdvance),
    .i_branch     (w_pcBranch),
    .i_jumpOffset (jump_offset),
    .o_pc         (pc)
  );

  assign instr   = r_instr;
  assign instret = r_instret;

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
Parameters:
REQ-001 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 NOP_INSTR, 32'h0000_0013, instruction register value on reset (ADDI x0,x0,0).

Ports:
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  instruction fetch request at address pc.
REQ-006 imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 instr  out  32  instruction register, driven to instr_decoder.
REQ-009 op_code  in  5  OpCode returned by instr_decoder from instr.
REQ-010 jump_offset  in  12  signed branch offset from instr_decoder.
REQ-011 branch_taken  in  1  ALU comparison result, valid in EXEC.
REQ-012 pc  out  32  current program counter.
REQ-013 alu_src_imm  out  1  ALU operand B is immediate (OP_IMM, LOAD, STORE, LUI).
REQ-014 dmem_req  out  1  data memory request.
REQ-015 dmem_we  out  1  data memory write (STORE); valid only with dmem_req.
REQ-016 dmem_ack  in  1  data access complete.
REQ-017 reg_we  out  1  register file write strobe, one cycle.
REQ-018 illegal  out  1  sticky illegal-instruction flag.
REQ-019 instret  out  32  retired-instruction counter.

Function
REQ-020 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP; state is registered, outputs decoded from state and the latched opcode.
REQ-021 FETCH: imem_req=1 held until imem_ack; the same cycle ack is sampled, instr<=imem_rdata and next state is DECODE; with no ack, remain in FETCH.
REQ-022 DECODE: one cycle; imem_rdata[1:0]!=2'b11 or op_code not in {LOAD,STORE,BRANCH,OP_IMM,OP,LUI} -> TRAP, else EXEC.
REQ-023 EXEC: OP/OP_IMM/LUI -> WB; LOAD/STORE -> MEM; BRANCH -> FETCH with pc update.
REQ-024 MEM: dmem_req=1 (dmem_we=1 for STORE) held until dmem_ack; on ack, LOAD -> WB, STORE -> FETCH with pc<=pc+4.
REQ-025 WB: reg_we=1 for exactly this cycle; pc<=pc+4; -> FETCH.
REQ-026 Branch: taken -> pc<=pc+sext({jump_offset,1'b0}); not taken -> pc<=pc+4.
REQ-027 All pc arithmetic is modulo 2^32; wrap-around is silent.
REQ-028 instret increments by 1 on each transition into FETCH from EXEC, MEM, or WB, and wraps 32'hFFFF_FFFF -> 0.
REQ-029 TRAP: illegal=1, all request and strobe outputs are 0, pc is frozen, and the state is held until reset.
REQ-030 Zero-wait latency (ack in the first request cycle): ALU op 4 cycles, LOAD 5, STORE 4, BRANCH 3.
REQ-031 imem_req and dmem_req are never asserted in the same cycle; an ack arriving while its req=0 is ignored.

Reset
REQ-032 Asserting rst_n=0 at any time, including mid-fetch or mid-access, immediately forces: state=FETCH, pc=RESET_PC, instr=NOP_INSTR, instret=0, illegal=0, imem_req=dmem_req=dmem_we=reg_we=alu_src_imm=0.
REQ-033 After rst_n deasserts, imem_req=1 in the first clock cycle with pc=RESET_PC.

Structure
REQ-034 A shared package holds OpCode, RegAddr, the Instruction structs, the SeqState enum and the NOP_INSTR constant.
REQ-035 A pc_unit sub-module (registered pc, +4 and branch adders) is instantiated; the FSM and instret live in core_sequencer.

Verification
REQ-036 Reset, then OP at 0 with zero-wait ack -> reg_we pulses in cycle 4, pc=4, instret=1.
REQ-037 LOAD with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0, then reg_we=1 once, pc=4.
REQ-038 BRANCH at pc=0x100 with jump_offset=-8 and taken=1 -> pc=0xF0; with taken=0 -> pc=0x104; reg_we stays 0.
REQ-039 Fetch of 32'h0000_0000 (low bits 00) -> TRAP, illegal=1, imem_req=0 for all following cycles until reset.
REQ-040 rst_n pulsed low during MEM of a STORE -> dmem_req drops asynchronously, pc=0, instret=0, and fetch restarts.
REQ-041 Preload instret=32'hFFFF_FFFF (force) and retire one instruction -> instret=0; preload pc=32'hFFFF_FFFC and execute OP -> pc=0.
